// File: rtl/bit_permute_pkg.sv
// -----------------------------------------------------------------------------
// bit_permute_pkg
//   Shared types for the bit_permute_stream slice.
//   mode_t : per-beat permutation selector carried alongside the input data.
//   occ_t  : occupancy of the two-entry output store (main + skid).
// -----------------------------------------------------------------------------
package bit_permute_pkg;

    typedef enum logic [1:0] {
        MODE_PASS    = 2'd0,
        MODE_BIT_REV = 2'd1,
        MODE_GRP_REV = 2'd2,
        MODE_ROTL    = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

endpackage

// File: rtl/bit_permute_core.sv
// -----------------------------------------------------------------------------
// bit_permute_core
//   Purely combinational permutation network.
//   Parameters:
//     WIDTH  data width in bits (>= 2)
//     GROUP  group size for group reversal (must divide WIDTH)
//     ROT_W  width of the rotate amount; amounts >= WIDTH wrap modulo WIDTH
//   Ports:
//     data_i  in  WIDTH  data to permute
//     mode_i  in  mode_t permutation select
//     rot_i   in  ROT_W  rotate-left amount (MODE_ROTL only)
//     data_o  out WIDTH  permuted data
// -----------------------------------------------------------------------------
module bit_permute_core
    import bit_permute_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GROUP = 1,
    parameter int ROT_W = 3
) (
    input  logic [WIDTH-1:0] data_i,
    input  mode_t            mode_i,
    input  logic [ROT_W-1:0] rot_i,
    output logic [WIDTH-1:0] data_o
);

    localparam int NGRP = WIDTH / GROUP;

    if (WIDTH < 2) begin : g_bad_width
        $error("bit_permute_core: WIDTH must be >= 2");
    end
    if (GROUP < 1 || (WIDTH % GROUP) != 0) begin : g_bad_group
        $error("bit_permute_core: GROUP must evenly divide WIDTH");
    end

    logic [WIDTH-1:0] bit_rev;
    logic [WIDTH-1:0] grp_rev;
    logic [WIDTH-1:0] rot_l;
    logic [31:0]      rot_amt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit_rev
        assign bit_rev[i] = data_i[WIDTH-1-i];
    end

    // Groups swap end-for-end; bit order inside each group is preserved.
    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        for (genvar b = 0; b < GROUP; b++) begin : g_grp_bit
            assign grp_rev[g*GROUP+b] = data_i[(NGRP-1-g)*GROUP+b];
        end
    end

    // With rot_amt == 0 the right shift is by WIDTH, which yields zero, so the
    // OR collapses to a plain pass-through.
    always_comb begin
        rot_amt = 32'(rot_i) % 32'(WIDTH);
        rot_l   = (data_i << rot_amt) | (data_i >> (32'(WIDTH) - rot_amt));
    end

    always_comb begin
        data_o = data_i;
        case (mode_i)
            MODE_PASS:    data_o = data_i;
            MODE_BIT_REV: data_o = bit_rev;
            MODE_GRP_REV: data_o = grp_rev;
            MODE_ROTL:    data_o = rot_l;
            default:      data_o = data_i;
        endcase
    end

endmodule

// File: rtl/bit_permute_stream.sv
// -----------------------------------------------------------------------------
// bit_permute_stream
//   Streaming bit/group permuter with valid/ready on both sides. The beat is
//   permuted on the way in and stored in a main register backed by a skid
//   register, giving one beat per cycle with a registered in_ready.
//
//   Optional build macro: BIT_PERMUTE_PARITY_EN adds out_parity (XOR of
//   out_data), stored alongside the data.
//
//   Ports:
//     clk         in   1      rising-edge clock
//     resetn      in   1      synchronous reset, active-low
//     in_valid    in   1      input beat valid
//     in_ready    out  1      input beat can be accepted (registered)
//     in_data     in   WIDTH  input data
//     in_mode     in   2      per-beat mode (mode_t)
//     in_rot      in   ROT_W  rotate-left amount for MODE_ROTL
//     out_valid   out  1      output beat valid
//     out_ready   in   1      consumer accepts beat
//     out_data    out  WIDTH  permuted data
//     out_parity  out  1      XOR of out_data (BIT_PERMUTE_PARITY_EN only)
//
//   state     | meaning
//   OCC_EMPTY | nothing stored, out_valid low
//   OCC_ONE   | main holds the head beat, skid empty
//   OCC_FULL  | main holds head, skid holds next beat, in_ready low
// -----------------------------------------------------------------------------
module bit_permute_stream
    import bit_permute_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GROUP = 1,
    parameter int ROT_W = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    input  logic [ROT_W-1:0] in_rot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef BIT_PERMUTE_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    occ_t             state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] permuted;
    logic             accept;
    logic             drain;
    logic             ld_main_in;
    logic             ld_main_skid;
    logic             ld_skid;

    bit_permute_core #(
        .WIDTH (WIDTH),
        .GROUP (GROUP),
        .ROT_W (ROT_W)
    ) u_core (
        .data_i (in_data),
        .mode_i (mode_t'(in_mode)),
        .rot_i  (in_rot),
        .data_o (permuted)
    );

    // in_ready is the registered flag, masked while reset is held so the
    // producer never sees a ready during the reset cycle.
    assign in_ready  = in_ready_q & resetn;
    assign out_valid = (state_q != OCC_EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= OCC_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state_q)
            OCC_EMPTY: begin
                if (accept) begin
                    ld_main_in = 1'b1;
                    state_d    = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (accept && drain) begin
                    // Head leaves while the new beat takes its place.
                    ld_main_in = 1'b1;
                end else if (accept) begin
                    ld_skid = 1'b1;
                    state_d = OCC_FULL;
                end else if (drain) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (drain) begin
                    ld_main_skid = 1'b1;
                    state_d      = OCC_ONE;
                end
            end
            default: begin
                state_d = OCC_EMPTY;
            end
        endcase
        in_ready_d = (state_d != OCC_FULL);
    end

    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (ld_main_in) begin
            main_d = permuted;
        end else if (ld_main_skid) begin
            main_d = skid_q;
        end
        if (ld_skid) begin
            skid_d = permuted;
        end else if (ld_main_skid) begin
            skid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

`ifdef BIT_PERMUTE_PARITY_EN
    logic par_in;
    logic par_main_q, par_main_d;
    logic par_skid_q, par_skid_d;

    assign par_in     = ^permuted;
    assign out_parity = par_main_q;

    always_comb begin
        par_main_d = par_main_q;
        par_skid_d = par_skid_q;
        if (ld_main_in) begin
            par_main_d = par_in;
        end else if (ld_main_skid) begin
            par_main_d = par_skid_q;
        end
        if (ld_skid) begin
            par_skid_d = par_in;
        end else if (ld_main_skid) begin
            par_skid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            par_main_q <= 1'b0;
            par_skid_q <= 1'b0;
        end else begin
            par_main_q <= par_main_d;
            par_skid_q <= par_skid_d;
        end
    end
`endif

endmodule
